// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 codes,
// FSM states and the byte-enable width.
package mem_lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int BE_WIDTH = 4;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_align.sv
// Lane steering for the 32-bit data bus: store byte enables/replication,
// load extraction with sign/zero extension, and the alignment check.
module mem_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]          funct3,
  input  logic [1:0]          off,
  input  logic [31:0]         sdata,
  input  logic [31:0]         rdata,
  output logic [BE_WIDTH-1:0] be,
  output logic [31:0]         wdata,
  output logic [31:0]         ldata,
  output logic                misalign
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rdata[{off, 3'b000} +: 8];
  assign rhalf = off[1] ? rdata[31:16] : rdata[15:0];

  // Sizing ignores funct3[2] so LBU/LHU share the byte/half lane logic.
  always_comb begin
    be       = 4'b1111;
    wdata    = sdata;
    misalign = |off;
    case (funct3)
      SB, LBU: begin
        be       = 4'b0001 << off;
        wdata    = {4{sdata[7:0]}};
        misalign = 1'b0;
      end
      SH, LHU: begin
        be       = off[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{sdata[15:0]}};
        misalign = off[0];
      end
      SW:      ;
      default: ;
    endcase
  end

  always_comb begin
    ldata = rdata;
    case (funct3)
      LB:      ldata = {{24{rbyte[7]}}, rbyte};
      LBU:     ldata = {24'd0, rbyte};
      LH:      ldata = {{16{rhalf[15]}}, rhalf};
      LHU:     ldata = {16'd0, rhalf};
      LW:      ldata = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM pipeline stage: ALU pass-through plus RV32 loads/stores over a
// req/gnt/rvalid bus, with stall, misalignment and timeout reporting.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int TIMEOUT     = 255,
  parameter int CNT_WIDTH   = $clog2(TIMEOUT + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   valid_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
  input  logic                   mem_re_i,
  input  logic                   mem_we_i,
  input  logic [2:0]             mem_funct3_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [DATA_WIDTH-1:0]  mem_sdata_i,
  output logic                   dbus_req_o,
  output logic                   dbus_we_o,
  output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
  output logic [BE_WIDTH-1:0]    dbus_be_o,
  output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
  input  logic                   dbus_gnt_i,
  input  logic                   dbus_rvalid_i,
  input  logic [DATA_WIDTH-1:0]  dbus_rdata_i,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [DATA_WIDTH-1:0]  reg_wdata_o,
  output logic                   stall_o,
  output logic                   misalign_o,
  output logic                   bus_err_o
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("mem_lsu: only DATA_WIDTH=32 is supported");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_lsu: TIMEOUT must be >= 1");
  end

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [1:0]             off_q;
  logic [2:0]             funct3_q;
  logic                   re_q;
  logic [RADDR_WIDTH-1:0] waddr_q;

  logic                   in_wait, is_mem, req;
  logic [2:0]             al_funct3;
  logic [1:0]             al_off;
  logic [BE_WIDTH-1:0]    al_be;
  logic [DATA_WIDTH-1:0]  al_wdata, al_ldata;
  logic                   al_mis;

  assign in_wait   = (state == MEM_WAIT);
  assign is_mem    = valid_i & (mem_re_i | mem_we_i);
  // The aligner formats the live request in IDLE and the latched one in WAIT.
  assign al_funct3 = in_wait ? funct3_q : mem_funct3_i;
  assign al_off    = in_wait ? off_q : mem_addr_i[1:0];
  assign req       = ~in_wait & is_mem & ~al_mis;

  mem_align u_align (
    .funct3   (al_funct3),
    .off      (al_off),
    .sdata    (mem_sdata_i),
    .rdata    (dbus_rdata_i),
    .be       (al_be),
    .wdata    (al_wdata),
    .ldata    (al_ldata),
    .misalign (al_mis)
  );

  // Outputs are forced low while reset is asserted, even mid-cycle.
  always_comb begin
    state_nxt    = state;
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = '0;
    dbus_be_o    = '0;
    dbus_wdata_o = '0;
    reg_waddr_o  = '0;
    reg_we_o     = 1'b0;
    reg_wdata_o  = '0;
    stall_o      = 1'b0;
    misalign_o   = 1'b0;
    bus_err_o    = 1'b0;
    if (rst_n_i) begin
      case (state)
        MEM_IDLE: begin
          if (valid_i && !is_mem) begin
            reg_waddr_o = reg_waddr_i;
            reg_we_o    = reg_we_i;
            reg_wdata_o = reg_wdata_i;
          end else if (is_mem && al_mis) begin
            misalign_o = 1'b1;
          end else if (req) begin
            dbus_req_o   = 1'b1;
            dbus_we_o    = mem_we_i;
            dbus_addr_o  = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
            dbus_be_o    = al_be;
            dbus_wdata_o = al_wdata;
            stall_o      = 1'b1;
            if (dbus_gnt_i) state_nxt = MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          stall_o = 1'b1;
          if (dbus_rvalid_i) begin
            stall_o     = 1'b0;
            state_nxt   = MEM_IDLE;
            reg_waddr_o = waddr_q;
            reg_we_o    = re_q;
            reg_wdata_o = re_q ? al_ldata : '0;
          end else if (cnt == CNT_WIDTH'(TIMEOUT)) begin
            stall_o   = 1'b0;
            bus_err_o = 1'b1;
            state_nxt = MEM_IDLE;
          end
        end
        default: state_nxt = MEM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= MEM_IDLE;
      cnt      <= '0;
      off_q    <= '0;
      funct3_q <= '0;
      re_q     <= 1'b0;
      waddr_q  <= '0;
    end else begin
      state <= state_nxt;
      if (req && dbus_gnt_i) begin
        off_q    <= mem_addr_i[1:0];
        funct3_q <= mem_funct3_i;
        re_q     <= mem_re_i;
        waddr_q  <= reg_waddr_i;
        cnt      <= '0;
      end else if (in_wait) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a transaction-level model predicts every
// output each cycle; literal expectations pin the key scenarios.
module tb_mem_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        valid = 0, reg_we = 0, mem_re = 0, mem_we = 0, gnt = 0, rvalid = 0;
  logic [4:0]  reg_waddr = '0;
  logic [31:0] reg_wdata = '0, mem_addr = '0, mem_sdata = '0, rdata = '0;
  logic [2:0]  mem_f3 = '0;
  logic        req, dwe, o_we, stall, mis, berr;
  logic [31:0] daddr, dwdata, o_wdata;
  logic [3:0]  dbe;
  logic [4:0]  o_waddr;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid),
    .reg_waddr_i(reg_waddr), .reg_we_i(reg_we), .reg_wdata_i(reg_wdata),
    .mem_re_i(mem_re), .mem_we_i(mem_we), .mem_funct3_i(mem_f3),
    .mem_addr_i(mem_addr), .mem_sdata_i(mem_sdata),
    .dbus_req_o(req), .dbus_we_o(dwe), .dbus_addr_o(daddr), .dbus_be_o(dbe),
    .dbus_wdata_o(dwdata), .dbus_gnt_i(gnt), .dbus_rvalid_i(rvalid),
    .dbus_rdata_i(rdata), .reg_waddr_o(o_waddr), .reg_we_o(o_we),
    .reg_wdata_o(o_wdata), .stall_o(stall), .misalign_o(mis), .bus_err_o(berr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_busy = 0, m_load = 0;
  int          m_wait = 0;
  logic [1:0]  m_off = '0;
  logic [2:0]  m_f3 = '0;
  logic [4:0]  m_waddr = '0;

  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit misal(input logic [31:0] a, input logic [2:0] f3);
    return (a % nbytes(f3)) != 0;
  endfunction

  function automatic bit exp_req();
    return rst_n && !m_busy && valid && (mem_re || mem_we) && !misal(mem_addr, mem_f3);
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] off,
                                          input logic [2:0] f3);
    int n, sh;
    logic [31:0] v, mask;
    n = nbytes(f3);
    if (n == 4) return d;
    sh   = (n == 1) ? 8 * int'(off) : 16 * (int'(off) / 2);
    mask = (32'h1 << (8 * n)) - 32'h1;
    v    = (d >> sh) & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] st_wdata(input logic [31:0] sd, input logic [2:0] f3);
    int n;
    logic [31:0] w;
    n = nbytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [3:0] st_be(input logic [1:0] off, input logic [2:0] f3);
    return 4'(((1 << nbytes(f3)) - 1) << off);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0;
      m_wait <= 0;
    end else if (!m_busy) begin
      if (exp_req() && gnt) begin
        m_busy  <= 1;
        m_wait  <= 0;
        m_off   <= mem_addr[1:0];
        m_f3    <= mem_f3;
        m_load  <= mem_re;
        m_waddr <= reg_waddr;
      end
    end else if (rvalid || m_wait == TO) begin
      m_busy <= 0;
    end else begin
      m_wait <= m_wait + 1;
    end
  end

  always @(negedge clk) begin : cmp
    logic        e_req, e_stall, e_mis, e_berr, e_rwe;
    logic [31:0] e_rwdata;
    logic [4:0]  e_waddr;
    bit          show;
    e_req = 0; e_stall = 0; e_mis = 0; e_berr = 0; e_rwe = 0;
    e_rwdata = '0; e_waddr = '0; show = !rst_n;
    if (rst_n) begin
      if (!m_busy) begin
        if (valid && !mem_re && !mem_we) begin
          show = 1; e_rwe = reg_we; e_waddr = reg_waddr; e_rwdata = reg_wdata;
        end else if (valid) begin
          if (misal(mem_addr, mem_f3)) e_mis = 1;
          else begin e_req = 1; e_stall = 1; end
        end
      end else begin
        e_stall = 1;
        if (rvalid) begin
          e_stall = 0;
          if (m_load) begin
            show = 1; e_rwe = 1; e_waddr = m_waddr;
            e_rwdata = extract(rdata, m_off, m_f3);
          end
        end else if (m_wait == TO) begin
          e_berr = 1; e_stall = 0;
        end
      end
    end
    chk("m_req", 32'(req), 32'(e_req));
    chk("m_stall", 32'(stall), 32'(e_stall));
    chk("m_misalign", 32'(mis), 32'(e_mis));
    chk("m_bus_err", 32'(berr), 32'(e_berr));
    chk("m_reg_we", 32'(o_we), 32'(e_rwe));
    if (show) begin
      chk("m_reg_waddr", 32'(o_waddr), 32'(e_waddr));
      chk("m_reg_wdata", o_wdata, e_rwdata);
    end
    if (!rst_n) begin
      chk("m_rst_bus", {dwe, dbe, 27'd0}, 32'd0);
      chk("m_rst_addr", daddr, 32'd0);
      chk("m_rst_wdata", dwdata, 32'd0);
    end else if (e_req) begin
      chk("m_dbus_we", 32'(dwe), 32'(mem_we));
      chk("m_dbus_addr", daddr, mem_addr & ~32'd3);
      if (mem_we) begin
        chk("m_dbus_be", 32'(dbe), 32'(st_be(mem_addr[1:0], mem_f3)));
        chk("m_dbus_wdata", dwdata, st_wdata(mem_sdata, mem_f3));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    valid = 0; reg_we = 0; mem_re = 0; mem_we = 0; reg_wdata = '0;
  endtask

  task automatic issue(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] wa);
    valid = 1; mem_re = ld; mem_we = !ld; mem_f3 = f3; mem_addr = a;
    mem_sdata = sd; reg_waddr = wa; reg_we = ld; reg_wdata = 32'h0BAD_0000;
  endtask

  task automatic do_mem(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int gd,
                        input int rspd, input bit same_rv, input logic [3:0] ebe,
                        input logic [31:0] ev);
    issue(ld, f3, a, sd, 5'd9);
    gnt = 0; rvalid = 0;
    repeat (gd) begin
      @(negedge clk);
      chk("hold_req", 32'(req), 32'd1);
      step();
    end
    gnt = 1; rvalid = same_rv; rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("req_addr", daddr, a & ~32'd3);
    if (!ld) begin
      chk("st_be", 32'(dbe), 32'(ebe));
      chk("st_wdata", dwdata, ev);
      chk("st_we", 32'(dwe), 32'd1);
    end
    step();
    gnt = 0; rvalid = 0;
    repeat (rspd) step();
    rvalid = 1; rdata = rd;
    @(negedge clk);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_we", 32'(o_we), 32'(ld));
    if (ld) chk("ld_data", o_wdata, ev);
    step();
    rvalid = 0;
    clr();
  endtask

  task automatic do_mis(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    issue(ld, f3, a, 32'h1111_2222, 5'd3);
    @(negedge clk);
    chk("mis_pulse", 32'(mis), 32'd1);
    chk("mis_req", 32'(req), 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    chk("mis_we", 32'(o_we), 32'd0);
    step();
    clr();
    @(negedge clk);
    chk("mis_clear", 32'(mis), 32'd0);
    step();
  endtask

  initial begin
    // reset with a pass-through instruction present: outputs must still be 0
    valid = 1; reg_we = 1; reg_waddr = 5'd4; reg_wdata = 32'h55;
    @(negedge clk);
    chk("rst_we", 32'(o_we), 32'd0);
    chk("rst_wdata", o_wdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    step();
    rst_n = 1;
    clr();
    step();

    // ALU pass-through
    valid = 1; reg_waddr = 5'd5; reg_we = 1; reg_wdata = 32'h1234;
    @(negedge clk);
    chk("pt_waddr", 32'(o_waddr), 32'd5);
    chk("pt_wdata", o_wdata, 32'h1234);
    chk("pt_stall", 32'(stall), 32'd0);
    chk("pt_req", 32'(req), 32'd0);
    step();
    valid = 0;
    @(negedge clk);
    chk("novalid_we", 32'(o_we), 32'd0);
    step();

    // LB sign-extend, cycle-exact
    issue(1, 3'b000, 32'h103, 32'd0, 5'd7);
    gnt = 1;
    @(negedge clk);
    chk("lb_addr", daddr, 32'h100);
    chk("lb_stall0", 32'(stall), 32'd1);
    step();
    gnt = 0;
    @(negedge clk);
    chk("lb_stall1", 32'(stall), 32'd1);
    chk("lb_req1", 32'(req), 32'd0);
    step();
    rvalid = 1; rdata = 32'h80FF_FFFF;
    @(negedge clk);
    chk("lb_data", o_wdata, 32'hFFFF_FF80);
    chk("lb_we", 32'(o_we), 32'd1);
    chk("lb_waddr", 32'(o_waddr), 32'd7);
    chk("lb_stall2", 32'(stall), 32'd0);
    step();
    rvalid = 0;
    clr();

    // loads (rdata 0x1234_8765)
    do_mem(1, 3'b100, 32'h201, 0, 32'h1234_8765, 1, 0, 0, 0, 32'h0000_0087);
    do_mem(1, 3'b000, 32'h201, 0, 32'h1234_8765, 0, 2, 0, 0, 32'hFFFF_FF87);
    do_mem(1, 3'b001, 32'h202, 0, 32'h1234_8765, 2, 1, 0, 0, 32'h0000_1234);
    do_mem(1, 3'b001, 32'h200, 0, 32'h1234_8765, 0, 0, 0, 0, 32'hFFFF_8765);
    do_mem(1, 3'b101, 32'h200, 0, 32'h1234_8765, 0, 1, 0, 0, 32'h0000_8765);
    do_mem(1, 3'b010, 32'h204, 0, 32'h1234_8765, 0, 0, 1, 0, 32'h1234_8765);
    do_mem(1, 3'b011, 32'h208, 0, 32'h1234_8765, 1, 0, 0, 0, 32'h1234_8765);
    do_mem(1, 3'b110, 32'h20C, 0, 32'h1234_8765, 0, 3, 1, 0, 32'h1234_8765);

    // stores
    do_mem(0, 3'b001, 32'h202, 32'hDEAD_BEEF, 0, 0, 0, 0, 4'b1100, 32'hBEEF_BEEF);
    do_mem(0, 3'b000, 32'h301, 32'h0000_00A5, 0, 1, 1, 0, 4'b0010, 32'hA5A5_A5A5);
    do_mem(0, 3'b000, 32'h303, 32'h1234_5678, 0, 0, 0, 0, 4'b1000, 32'h7878_7878);
    do_mem(0, 3'b001, 32'h300, 32'hCAFE_1234, 0, 0, 2, 0, 4'b0011, 32'h1234_1234);
    do_mem(0, 3'b010, 32'h304, 32'h0123_4567, 0, 2, 0, 1, 4'b1111, 32'h0123_4567);

    // misaligned
    do_mis(1, 3'b010, 32'h101);
    do_mis(1, 3'b001, 32'h103);
    do_mis(0, 3'b001, 32'h201);
    do_mis(0, 3'b010, 32'h302);

    // timeout: four waiting cycles, then the error pulse
    issue(1, 3'b010, 32'h400, 0, 5'd11);
    gnt = 1;
    @(negedge clk);
    chk("to_req", 32'(req), 32'd1);
    step();
    gnt = 0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      chk("to_wait_stall", 32'(stall), 32'd1);
      chk("to_wait_err", 32'(berr), 32'd0);
      step();
    end
    @(negedge clk);
    chk("to_err", 32'(berr), 32'd1);
    chk("to_stall", 32'(stall), 32'd0);
    chk("to_we", 32'(o_we), 32'd0);
    step();
    clr();
    rvalid = 1; rdata = 32'h7777_7777;
    @(negedge clk);
    chk("to_err_clear", 32'(berr), 32'd0);
    chk("to_late_we", 32'(o_we), 32'd0);
    step();
    rvalid = 0;

    // async reset while waiting for the response
    issue(1, 3'b010, 32'h500, 0, 5'd12);
    gnt = 1;
    step();
    gnt = 0;
    #2 rst_n = 0;
    #1;
    chk("ar_stall", 32'(stall), 32'd0);
    chk("ar_req", 32'(req), 32'd0);
    chk("ar_we", 32'(o_we), 32'd0);
    step();
    clr();
    step();
    rst_n = 1;
    rvalid = 1; rdata = 32'h1357_9BDF;
    @(negedge clk);
    chk("ar_late_we", 32'(o_we), 32'd0);
    chk("ar_late_stall", 32'(stall), 32'd0);
    step();
    rvalid = 0;

    // recovery after reset
    do_mem(1, 3'b010, 32'h600, 0, 32'hA5A5_0F0F, 0, 0, 0, 0, 32'hA5A5_0F0F);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
